// File: rtl/compare_seq_pkg.sv
// Shared types and helpers for the vector compare sequencer:
// FSM state encoding, settle-time limits and the saturating counter step.
package compare_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Settle time is held in an 8-bit down-counter.
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 255;
  localparam int TIMER_W    = 8;

  // Counters are handled through a 64-bit helper, so CNT_W may not exceed it.
  localparam int CNT_W_MAX  = 64;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable 8-bit down-counter used to time the DUT settle interval.
// load has priority over en; the count holds once it reaches zero.
module settle_timer
  import compare_seq_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  // Load on request, otherwise count down while enabled and not yet empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vector_compare_seq.sv
// Stimulus/compare sequencer: fetches {stimulus, expected} records from a
// pattern source, drives the stimulus onto the circuit under test, waits the
// settle time, samples and compares the response, and keeps run statistics.
// Optional build macro: COMPARE_MASK_EN adds a per-vector compare mask port
// (pat_mask); without it every output bit is compared.
module vector_compare_seq
  import compare_seq_pkg::*;
#(
  parameter int STIM_W = 2,
  parameter int EXP_W  = 1,
  parameter int SETTLE = 19,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pat_valid,
  output logic              pat_ready,
  input  logic [STIM_W-1:0] pat_stim,
  input  logic [EXP_W-1:0]  pat_expect,
`ifdef COMPARE_MASK_EN
  input  logic [EXP_W-1:0]  pat_mask,
`endif
  input  logic              pat_last,
  output logic [STIM_W-1:0] dut_stim,
  input  logic [EXP_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic              first_err_vld
);

  // Elaboration-time guard on the configuration.
  if ((SETTLE < SETTLE_MIN) || (SETTLE > SETTLE_MAX)) begin : g_bad_settle
    $error("vector_compare_seq: SETTLE must be within 1..255");
  end
  if ((CNT_W < 1) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
    $error("vector_compare_seq: CNT_W must be within 1..64");
  end

  // One vector spans FETCH (1 cycle) + WAIT (SETTLE-1 cycles) + CHECK
  // (1 cycle), so the response is sampled SETTLE edges after the stimulus
  // update. The timer is loaded so that it reaches zero in the last WAIT
  // cycle; with SETTLE==1 there is no WAIT cycle and FETCH goes to CHECK.
  localparam logic [TIMER_W-1:0] TMR_LOAD  = (SETTLE >= 2) ? TIMER_W'(SETTLE - 2) : '0;
  localparam logic               SKIP_WAIT = (SETTLE == 1);
  localparam logic [63:0]        CNT_ONES  = 64'({CNT_W{1'b1}});

  state_t             state;
  logic [EXP_W-1:0]   exp_q;
  logic               last_q;
  logic [EXP_W-1:0]   diff;
  logic               fail;
  logic               accept;
  logic               tmr_zero;

`ifdef COMPARE_MASK_EN
  logic [EXP_W-1:0]   mask_q;

  // Latch the compare mask alongside the expected value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= pat_mask;
    end
  end

  assign diff = (dut_out ^ exp_q) & mask_q;
`else
  assign diff = dut_out ^ exp_q;
`endif

  assign fail   = |diff;
  assign accept = (state == FETCH) && pat_valid && !abort;

  settle_timer u_settle_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val (TMR_LOAD),
    .en       (state == WAIT),
    .zero     (tmr_zero)
  );

  // Sequencer FSM together with the stimulus, latched record and run counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      dut_stim      <= '0;
      exp_q         <= '0;
      last_q        <= 1'b0;
      mismatch      <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (abort) begin
        // Abort leaves counters and stimulus as they are and skips any compare.
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              vec_count     <= '0;
              err_count     <= '0;
              first_err_idx <= '0;
              first_err_vld <= 1'b0;
              state         <= FETCH;
            end
          end
          FETCH: begin
            if (pat_valid) begin
              dut_stim <= pat_stim;
              exp_q    <= pat_expect;
              last_q   <= pat_last;
              state    <= SKIP_WAIT ? CHECK : WAIT;
            end
          end
          WAIT: begin
            if (tmr_zero) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            vec_count <= CNT_W'(sat_inc(64'(vec_count), CNT_ONES));
            if (fail) begin
              err_count <= CNT_W'(sat_inc(64'(err_count), CNT_ONES));
              mismatch  <= 1'b1;
              if (!first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_idx <= vec_count;
              end
            end
            state <= last_q ? DONE : FETCH;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pat_ready = (state == FETCH);
  assign busy      = (state == FETCH) || (state == WAIT) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = (state == DONE) && (err_count == '0);

endmodule
